// File: rtl/square1_frame_seq.sv
// square1_frame_seq: pixel-clock frame sequencer with pause, reverse, speed divider and palette latch.
// Define SQUARE1_SEQ_STEP_EN to enable single-step (STEP_ARMED state, ctrl_i[2]).
module square1_frame_seq #(
   parameter int FRAME_W = 9,
   parameter int DIV_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync_i,
   input  logic [7:0]         ctrl_i,
   output logic [FRAME_W-1:0] frame_no,
   output logic [1:0]         palette_o,
   output logic               frame_tick,
   output logic [1:0]         state_o
);
`ifdef SQUARE1_SEQ_STEP_EN
   typedef enum logic [1:0] {RUN = 2'd0, PAUSE = 2'd1, STEP_ARMED = 2'd2} state_t;
`else
   typedef enum logic [1:0] {RUN = 2'd0, PAUSE = 2'd1} state_t;
`endif
   state_t state;
   logic [7:0] ctrl_m, ctrl_s;
   logic vs_d, frame_evt, pause, reverse, adv;
   logic [DIV_W-1:0] speed, div_cnt;
   assign frame_evt = vsync_i & ~vs_d;
   assign pause = ctrl_s[0];
   assign reverse = ctrl_s[1];
   assign speed = ctrl_s[DIV_W+2:3];
   assign state_o = state;
`ifdef SQUARE1_SEQ_STEP_EN
   logic step_d, step_rise;
   assign step_rise = ctrl_s[2] & ~step_d;
   assign adv = frame_evt & (((state == RUN) & ~pause & (div_cnt >= speed)) | (state == STEP_ARMED));
`else
   logic step_unused;
   assign step_unused = ctrl_s[2];
   assign adv = frame_evt & (state == RUN) & ~pause & (div_cnt >= speed);
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ctrl_m     <= '0;
         ctrl_s     <= '0;
         vs_d       <= 1'b1;
         state      <= RUN;
         div_cnt    <= '0;
         frame_no   <= '0;
         palette_o  <= '0;
         frame_tick <= 1'b0;
`ifdef SQUARE1_SEQ_STEP_EN
         step_d     <= 1'b1;
`endif
      end else begin
         ctrl_m     <= ctrl_i;
         ctrl_s     <= ctrl_m;
         vs_d       <= vsync_i;
`ifdef SQUARE1_SEQ_STEP_EN
         step_d     <= ctrl_s[2];
`endif
         frame_tick <= adv;
         if (adv) frame_no <= reverse ? frame_no - FRAME_W'(1) : frame_no + FRAME_W'(1);
         if (frame_evt) palette_o <= ctrl_s[7:6];
         case (state)
            RUN:
               if (frame_evt) begin
                  if (pause) state <= PAUSE;
                  else div_cnt <= (div_cnt >= speed) ? '0 : div_cnt + DIV_W'(1);
               end
            PAUSE:
               // frame_evt wins over a coincident step edge
               if (frame_evt) begin
                  if (!pause) begin
                     state   <= RUN;
                     div_cnt <= '0;
                  end
               end
`ifdef SQUARE1_SEQ_STEP_EN
               else if (step_rise) state <= STEP_ARMED;
            STEP_ARMED:
               if (frame_evt) begin
                  if (pause) state <= PAUSE;
                  else begin
                     state   <= RUN;
                     div_cnt <= '0;
                  end
               end
`endif
            default: state <= RUN;
         endcase
      end
endmodule

// File: tb/tb_square1_frame_seq.sv
// tb_square1_frame_seq: random and directed stimulus checked every cycle against a behavioural model.
module tb_square1_frame_seq;
   localparam int FW = 9;
   localparam int FMOD = 1 << FW;
`ifdef SQUARE1_SEQ_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0;
   logic [7:0] ctrl = 8'h00;
   logic [FW-1:0] frame_no;
   logic [1:0] palette_o, state_o;
   logic frame_tick;
   int n_run = 0, n_fail = 0;
   bit chk_en = 1'b0;
   int exp_arm, exp_step;

   square1_frame_seq dut (
      .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .ctrl_i(ctrl),
      .frame_no(frame_no), .palette_o(palette_o), .frame_tick(frame_tick), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // older/newer hold the last two sampled ctrl values; the sequencer acts on the older one
   typedef struct {
      int frame; int pal; int tick; int state; int wait_n;
      logic [7:0] older; logic [7:0] newer; bit vs; bit stp;
   } mdl_t;
   mdl_t m;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.frame = 0; r.pal = 0; r.tick = 0; r.state = 0; r.wait_n = 0;
      r.older = 8'h00; r.newer = 8'h00; r.vs = 1'b1; r.stp = 1'b1;
      return r;
   endfunction

   function automatic mdl_t mdl_next(mdl_t c, logic [7:0] in, logic vs);
      mdl_t n = c;
      logic [7:0] cs = c.older;
      bit evt = vs && !c.vs;
      bit rise = STEP_EN && cs[2] && !c.stp;
      bit go = 1'b0;
      n.older = c.newer; n.newer = in; n.vs = vs; n.stp = cs[2]; n.tick = 0;
      if (evt) begin
         n.pal = int'(cs[7:6]);
         if (c.state == 2) begin go = 1'b1; n.state = cs[0] ? 1 : 0; end
         else if (c.state == 1) n.state = cs[0] ? 1 : 0;
         else if (cs[0]) n.state = 1;
         else if (c.wait_n >= int'(cs[5:3])) go = 1'b1;
         else n.wait_n = c.wait_n + 1;
         if (go || (n.state == 0 && c.state != 0)) n.wait_n = 0;
         if (go) begin
            n.frame = (c.frame + (cs[1] ? FMOD - 1 : 1)) % FMOD;
            n.tick = 1;
         end
      end else if (rise && c.state == 1) n.state = 2;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) m <= mdl_reset();
      else m <= mdl_next(m, ctrl, vsync);

   task automatic check(string nm, int act, int exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (chk_en) begin
         check("model_frame_no", int'(frame_no), m.frame);
         check("model_palette", int'(palette_o), m.pal);
         check("model_frame_tick", int'(frame_tick), m.tick);
         check("model_state", int'(state_o), m.state);
      end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      vsync = 1'b1;
      cyc(2);
      vsync = 1'b0;
      cyc(4);
   endtask

   task automatic do_reset(logic [7:0] c);
      rst_n = 1'b0;
      ctrl = c;
      vsync = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
   endtask

   initial begin
      exp_arm = STEP_EN ? 2 : 1;
      exp_step = STEP_EN ? 2 : 1;
      cyc(1);
      chk_en = 1'b1;
      do_reset(8'h00);
      check("reset_frame", int'(frame_no), 0);
      check("reset_palette", int'(palette_o), 0);
      check("reset_tick", int'(frame_tick), 0);
      check("reset_state", int'(state_o), 0);
      for (int i = 1; i <= 3; i++) begin
         pulse();
         check("free_run", int'(frame_no), i);
      end
      do_reset(8'h02);
      pulse();
      check("rev_wrap_a", int'(frame_no), 511);
      pulse();
      check("rev_wrap_b", int'(frame_no), 510);
      ctrl = 8'h00;
      cyc(3);
      pulse();
      check("fwd_wrap_a", int'(frame_no), 511);
      pulse();
      check("fwd_wrap_b", int'(frame_no), 0);
      pulse();
      check("fwd_wrap_c", int'(frame_no), 1);
      do_reset(8'h18);
      for (int i = 1; i <= 8; i++) begin
         pulse();
         check("speed3", int'(frame_no), i / 4);
      end
      pulse();
      pulse();
      check("speed3_hold", int'(frame_no), 2);
      ctrl = 8'h00;
      cyc(3);
      pulse();
      check("speed_lowered", int'(frame_no), 3);
      do_reset(8'h00);
      pulse();
      ctrl = 8'h01;
      cyc(3);
      pulse();
      check("pause_frame", int'(frame_no), 1);
      check("pause_state", int'(state_o), 1);
      ctrl = 8'h05;
      cyc(3);
      check("step_armed", int'(state_o), exp_arm);
      ctrl = 8'h01;
      cyc(3);
      ctrl = 8'h05;
      cyc(3);
      check("step_ignored", int'(state_o), exp_arm);
      pulse();
      check("step_frame", int'(frame_no), exp_step);
      check("step_back_pause", int'(state_o), 1);
      ctrl = 8'hC1;
      cyc(3);
      check("palette_hold", int'(palette_o), 0);
      pulse();
      check("palette_new", int'(palette_o), 3);
      check("palette_frame", int'(frame_no), exp_step);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_frame", int'(frame_no), 0);
      check("async_palette", int'(palette_o), 0);
      check("async_tick", int'(frame_tick), 0);
      check("async_state", int'(state_o), 0);
      ctrl = 8'h00;
      vsync = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      check("vs_high_reset", int'(frame_no), 0);
      vsync = 1'b0;
      cyc(2);
      check("vs_high_reset_after", int'(frame_no), 0);
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 7) == 0) ctrl = 8'($urandom);
         else if ($urandom_range(0, 7) == 0) ctrl[2] = ~ctrl[2];
         vsync = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 999) != 0);
         cyc(1);
      end
      rst_n = 1'b1;
      vsync = 1'b0;
      cyc(2);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/square1_frame_seq.md
# square1_frame_seq

Frame sequencer for the square1 VGA pattern renderer. It replaces the free-running frame counter clocked directly by vsync with a fully synchronous counter in the pixel-clock domain. The renderer's lagged XOR compare consumes its `frame_no` output. The block also lets the pin inputs pause, reverse, slow down or single-step the animation, and selects the palette. Every visible change is applied only at a frame boundary, so no frame is ever rendered with mixed settings.

## Interface
- `FRAME_W`, default 9: frame counter width; must match the renderer's compare width.
- `DIV_W`, default 3: width of the speed field and of the divider counter.

Ports:
- `clk`  in  1  pixel clock, same clock that drives `hvsync_generator`.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `vsync_i`  in  1  vsync from `hvsync_generator`; synchronous to `clk`; high during the sync pulse.
- `ctrl_i`  in  8  raw pin controls, asynchronous:
  - [0] pause
  - [1] reverse
  - [2] step
  - [DIV_W+2:3] speed
  - [7:6] palette
- `frame_no`  out  FRAME_W  current animation frame index.
- `palette_o`  out  2  palette select, latched once per frame.
- `frame_tick`  out  1  one-cycle pulse, high in the cycle in which `frame_no` holds a newly updated value.
- `state_o`  out  2  FSM state: 0 = RUN, 1 = PAUSE, 2 = STEP_ARMED.

## Operation
- **Input synchronisation**
  - `ctrl_i` passes through a 2-flop synchroniser; the synchronised copy is `ctrl_s`.
  - `vsync_i` is not synchronised.
- **Frame event**
  - `frame_evt = vsync_i & ~vs_d`, where `vs_d` is `vsync_i` registered.
  - `vs_d` resets to 1, so a vsync held high across reset release produces no event.
- **Palette**: `palette_o <= ctrl_s[7:6]` on every `frame_evt`, in all states.
- **Advance**
  - `frame_no <= frame_no + 1`, or `frame_no - 1` when `ctrl_s[1]` = 1 at that edge.
  - Arithmetic is modulo 2^FRAME_W: all-ones + 1 gives 0, and 0 - 1 gives all-ones.
- **Divider** (RUN only)
  - On each `frame_evt`, if `div_cnt >= speed`, advance and clear `div_cnt`; otherwise increment `div_cnt` without advancing.
  - speed = 0 advances every frame; speed = 7 advances every 8th frame.
  - Lowering speed below the current `div_cnt` advances on the next event.
- **FSM**: transitions are evaluated only on `frame_evt`, except step arming.
  - RUN: if `ctrl_s[0]` = 1, go to PAUSE with no advance on that event. Otherwise apply the divider.
  - PAUSE: on a rising edge of `ctrl_s[2]`, go to STEP_ARMED (this transition is immediate, not frame-gated). If `ctrl_s[0]` = 0 at `frame_evt`, go to RUN and clear `div_cnt`, with no advance on that event.
  - STEP_ARMED: on `frame_evt`, advance exactly once, ignoring the divider. Then go to PAUSE if `ctrl_s[0]` = 1, else RUN with `div_cnt` cleared.
- **Step edge rules**
  - Step rising edges are ignored in RUN and in STEP_ARMED; steps are never queued.
  - Step is edge-detected on `ctrl_s[2]`; the detector register resets to 1.
- **Simultaneous events**: if a step rising edge and `frame_evt` fall on the same cycle in PAUSE, `frame_evt` handling takes priority and the step is dropped.

## Timing
- **Reset values**: `frame_no` = 0, `palette_o` = 0, `frame_tick` = 0, `state_o` = 0 (RUN). Internally, `div_cnt` = 0 and the synchroniser flops = 0.
- **Reset mid-frame**: asynchronous assertion forces all reset values immediately, with no completion of pending steps.
- **frame_no latency**: `frame_no` and `palette_o` update on the same `clk` edge that first samples `vsync_i` high.
- **frame_tick**: high for exactly the following cycle, and only on advances.
- **Control latency**: a `ctrl_i` change is visible to the FSM 2 cycles later. It is honoured at the first `frame_evt` at least 2 cycles after the change.
- **Step-to-FSM latency**: `state_o` changes PAUSE→STEP_ARMED 3 edges after `ctrl_i[2]` rises (2 synchroniser cycles plus 1 for the state register).

## Configuration
- **`SQUARE1_SEQ_STEP_EN` defined**
  - The STEP_ARMED state and the step edge detector are present, and `ctrl_i[2]` is active.
- **`SQUARE1_SEQ_STEP_EN` undefined**
  - STEP_ARMED and the step logic are removed, and `ctrl_i[2]` is ignored.
  - `state_o` is only ever 0 or 1.
  - All other behaviour is identical.

## Test plan
- **Reset and free-run**: reset, then ctrl = 0 and 3 vsync pulses → `frame_no` = 1, 2, 3, each change accompanied by a 1-cycle `frame_tick`.
- **Wrap in reverse**: ctrl[1] = 1 from reset, 2 pulses → `frame_no` = 511, then 510. Then ctrl[1] = 0 for 3 pulses → 511, 0, 1.
- **Speed divider**: speed = 3 with 8 pulses → advances on pulses 4 and 8 only. Change speed to 0 when `div_cnt` = 2 → advance on the next pulse.
- **Pause and step** (macro defined)
  - Pause set mid-frame → the next pulse gives no advance and `state_o` = 1.
  - Step edge → `state_o` = 2 after 3 edges; the next pulse advances by exactly 1 and `state_o` returns to 1.
  - A second step while `state_o` = 2 is ignored.
- **Palette and reset boundaries**
  - Palette change mid-frame → `palette_o` is unchanged until the next pulse, then takes the new value.
  - `vsync_i` high through reset release → no advance.
  - `rst_n` asserted mid-frame → all outputs 0 immediately.
- **Macro undefined**: the pause-and-step sequence with step toggling → `state_o` never equals 2 and `frame_no` never changes while paused.
